cordic_phase_sweep_gen: RTL

Parametrised phase-stimulus generator for the CORDIC sin/cos core. It replaces the fixed 0..359 degree counter with a programmable sweep: configurable step, quadrant size and width, plus continuous, single-shot and ping-pong modes. Output is quadrant-coded phase {quadrant[1:0], angle}, presented over a valid/ready handshake so the CORDIC pipeline can apply back-pressure.

---
 rtl/cordic_phase_sweep_gen_if.sv | 24 ++
 rtl/cordic_phase_sweep_gen.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cordic_phase_sweep_gen_if.sv
// Phase stream between the sweep generator (master) and the CORDIC core (slave).
// Carries the quadrant-coded phase, the raw count behind it and the valid/ready pair.
interface cordic_phase_sweep_gen_if #(
    parameter int ANG_W = 16
);
    logic               Phase_Valid;
    logic               Phase_Ready;
    logic [ANG_W+1:0]   Phase;
    logic [ANG_W+1:0]   Cnt;

    modport master (
        output Phase_Valid,
        output Phase,
        output Cnt,
        input  Phase_Ready
    );

    modport slave (
        input  Phase_Valid,
        input  Phase,
        input  Cnt,
        output Phase_Ready
    );
endinterface

// File: rtl/cordic_phase_sweep_gen.sv
// Programmable phase sweep for the CORDIC core: continuous, single-shot and ping-pong.
// Optional revolution counter output Rev_Cnt is built when SWEEP_CNT_EN is defined.
//
// state  | meaning
// S_IDLE | waiting for Start, Phase_Valid low
// S_RUN  | presenting phases, count advances on each handshake
// S_DONE | single revolution finished, Done high for this one cycle
module cordic_phase_sweep_gen #(
    parameter int ANG_W     = 16,
    parameter int QUAD_UNIT = 90,
    parameter int STEP_W    = 16
) (
    input  logic                    CLK_50M,
    input  logic                    RST,
    input  logic                    Start,
    input  logic                    Stop,
    input  logic [1:0]              Mode,
    input  logic [STEP_W-1:0]       Step,
    cordic_phase_sweep_gen_if.master ph,
    output logic                    Busy,
    output logic                    Done
`ifdef SWEEP_CNT_EN
    ,
    output logic [15:0]             Rev_Cnt
`endif
);

    localparam int CW   = ANG_W + 2;
    localparam int SW   = ANG_W + 3;
    localparam int FULL = 4 * QUAD_UNIT;

    localparam logic [SW-1:0] FULL_S = SW'(FULL);
    localparam logic [SW-1:0] LAST_S = SW'(FULL - 1);
    localparam logic [SW-1:0] Q1_S   = SW'(QUAD_UNIT);
    localparam logic [SW-1:0] Q2_S   = SW'(2 * QUAD_UNIT);
    localparam logic [SW-1:0] Q3_S   = SW'(3 * QUAD_UNIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            valid_q, valid_d;
    logic            dir_q, dir_d;
    logic [1:0]      mode_q, mode_d;
    logic [SW-1:0]   step_q, step_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   phase_q, phase_d;

    logic [SW-1:0]   step_in;
    logic [SW-1:0]   cnt_ext;
    logic [SW-1:0]   sum;
    logic [SW-1:0]   cnt_nx;
    logic            start_ev;
    logic            wrap_ev;
    logic            done_ev;

    // Angle runs 0..QUAD_UNIT inclusive, so a quadrant boundary count stays in the lower quadrant.
    function automatic logic [CW-1:0] quad_map(input logic [SW-1:0] c);
        if (c <= Q1_S)
            return {2'd0, ANG_W'(c)};
        else if (c <= Q2_S)
            return {2'd1, ANG_W'(c - Q1_S)};
        else if (c <= Q3_S)
            return {2'd2, ANG_W'(c - Q2_S)};
        else
            return {2'd3, ANG_W'(c - Q3_S)};
    endfunction

    always_comb begin
        if (Step == '0)
            step_in = SW'(1);
        else if (32'(Step) >= 32'(FULL))
            step_in = LAST_S;
        else
            step_in = SW'(Step);
    end

    assign cnt_ext = SW'(cnt_q);
    assign sum     = cnt_ext + step_q;

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        dir_d    = dir_q;
        mode_d   = mode_q;
        step_d   = step_q;
        cnt_nx   = cnt_ext;
        start_ev = 1'b0;
        wrap_ev  = 1'b0;
        done_ev  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Start && !Stop) begin
                    state_d  = S_RUN;
                    valid_d  = 1'b1;
                    dir_d    = 1'b0;
                    mode_d   = Mode;
                    step_d   = step_in;
                    cnt_nx   = '0;
                    start_ev = 1'b1;
                end
            end
            S_RUN: begin
                if (Stop) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end else if (valid_q && ph.Phase_Ready) begin
                    case (mode_q)
                        2'd1: begin
                            // The wrapped value is never emitted; the last phase stays on the bus.
                            if (sum >= FULL_S) begin
                                state_d = S_DONE;
                                valid_d = 1'b0;
                                done_ev = 1'b1;
                            end else begin
                                cnt_nx = sum;
                            end
                        end
                        2'd2: begin
                            if (!dir_q) begin
                                if (sum >= LAST_S) begin
                                    cnt_nx = LAST_S;
                                    dir_d  = 1'b1;
                                end else begin
                                    cnt_nx = sum;
                                end
                            end else begin
                                if (cnt_ext <= step_q) begin
                                    cnt_nx  = '0;
                                    dir_d   = 1'b0;
                                    wrap_ev = 1'b1;
                                end else begin
                                    cnt_nx = cnt_ext - step_q;
                                end
                            end
                        end
                        default: begin
                            if (sum >= FULL_S) begin
                                cnt_nx  = sum - FULL_S;
                                wrap_ev = 1'b1;
                            end else begin
                                cnt_nx = sum;
                            end
                        end
                    endcase
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase

        cnt_d   = CW'(cnt_nx);
        phase_d = quad_map(cnt_nx);
    end

    always_ff @(posedge CLK_50M or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            dir_q   <= 1'b0;
            mode_q  <= '0;
            step_q  <= '0;
            cnt_q   <= '0;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign ph.Phase_Valid = valid_q;
    assign ph.Phase       = phase_q;
    assign ph.Cnt         = cnt_q;
    assign Busy           = (state_q == S_RUN);
    assign Done           = (state_q == S_DONE);

`ifdef SWEEP_CNT_EN
    logic [15:0] rev_q, rev_d;

    always_comb begin
        rev_d = rev_q;
        if (start_ev)
            rev_d = '0;
        else if (done_ev)
            rev_d = 16'd1;
        else if (wrap_ev)
            rev_d = rev_q + 16'd1;
    end

    always_ff @(posedge CLK_50M or posedge RST) begin
        if (RST)
            rev_q <= '0;
        else
            rev_q <= rev_d;
    end

    assign Rev_Cnt = rev_q;
`else
    logic unused_rev_ev;
    assign unused_rev_ev = start_ev ^ wrap_ev ^ done_ev;
`endif

endmodule
